// File: rtl/wb_port_arbiter_pkg.sv
// Shared encodings for the write-port arbiter: op codes, SFR addresses,
// IRQ push-sequencer states and the registered write-request record.
package wb_port_arbiter_pkg;

    localparam int RAM_OP_LEN = 2;
    localparam int SFR_OP_LEN = 3;

    localparam logic [RAM_OP_LEN-1:0] OP_RAM_NOP     = 2'd0;
    localparam logic [RAM_OP_LEN-1:0] OP_RAM_WR_BYTE = 2'd1;

    localparam logic [SFR_OP_LEN-1:0] OP_DEFAULT     = 3'd0;
    localparam logic [SFR_OP_LEN-1:0] OP_SP_WR_BYTE  = 3'd1;

    localparam logic [7:0] SP_ADDR = 8'h81;

    typedef enum logic [2:0] {
        IRQ_IDLE   = 3'd0,
        IRQ_PUSH_L = 3'd1,
        IRQ_PUSH_H = 3'd2,
        IRQ_SP_UPD = 3'd3,
        IRQ_DONE   = 3'd4
    } irq_state_e;

    typedef struct packed {
        logic [RAM_OP_LEN-1:0] ram_op;
        logic [SFR_OP_LEN-1:0] sfr_op;
        logic [7:0]            addr;
        logic [7:0]            data;
        logic [7:0]            psw;
    } wr_req_t;

endpackage

// File: rtl/wb_req_fifo.sv
// Small synchronous FIFO buffering peripheral SFR write requests.
// Pushes while full and pops while empty are dropped internally.
module wb_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign o_full  = (count_q == FULL_CNT);
    assign o_empty = (count_q == '0);
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;
    assign o_rdata = mem_q[rd_ptr_q];

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= i_wdata;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Single write port into internal RAM / SFR bank, shared by Stage3 write-back,
// the interrupt return-address push sequencer and buffered peripheral SFR writes.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int PER_FIFO_DEPTH = 4,
    parameter int STARVE_LIMIT   = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wb_valid,
    input  logic [RAM_OP_LEN-1:0] i_wb_ram_op,
    input  logic [SFR_OP_LEN-1:0] i_wb_sfr_op,
    input  logic [7:0]            i_wb_addr,
    input  logic [7:0]            i_wb_data,
    input  logic [7:0]            i_wb_psw,
    output logic                  o_wb_stall,
    input  logic                  i_irq_push,
    input  logic [15:0]           i_irq_pc,
    input  logic [7:0]            i_sp,
    output logic                  o_irq_busy,
    output logic                  o_irq_done,
    input  logic                  i_per_valid,
    input  logic [SFR_OP_LEN-1:0] i_per_sfr_op,
    input  logic [7:0]            i_per_data,
    output logic                  o_per_ready,
    output logic [RAM_OP_LEN-1:0] o_wr_ram_op,
    output logic [SFR_OP_LEN-1:0] o_wr_sfr_op,
    output logic [7:0]            o_wr_addr,
    output logic [7:0]            o_wr_data,
    output logic [7:0]            o_wr_psw,
    output irq_state_e            o_dbg_state
);

    localparam int FW = SFR_OP_LEN + 8;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    irq_state_e    state_q, state_d;
    logic [15:0]   pc_q;
    logic [7:0]    sp_q;
    logic [SW-1:0] starve_q, starve_d;
    wr_req_t       wr_q, wr_d;

    logic          fifo_full, fifo_empty;
    logic [FW-1:0] fifo_rdata;
    logic          irq_active, per_forced, wb_grant, per_grant;

    // Peripheral handshake: a request transfers on a cycle where i_per_valid
    // and o_per_ready are both high; the requester holds valid and payload until then.
    wb_req_fifo #(
        .DEPTH (PER_FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_per_valid && !fifo_full),
        .i_wdata ({i_per_sfr_op, i_per_data}),
        .i_pop   (per_grant),
        .o_rdata (fifo_rdata),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    // Grants come only from registered state and request inputs, never from o_wr_*.
    assign irq_active  = (state_q == IRQ_PUSH_L) || (state_q == IRQ_PUSH_H) ||
                         (state_q == IRQ_SP_UPD);
    assign per_forced  = (starve_q == STARVE_MAX) && !fifo_empty;
    assign wb_grant    = i_wb_valid && !irq_active && !per_forced;
    assign per_grant   = !irq_active && !fifo_empty && (per_forced || !i_wb_valid);

    assign o_wb_stall  = i_wb_valid && !wb_grant;
    assign o_irq_busy  = irq_active;
    assign o_irq_done  = (state_q == IRQ_DONE);
    assign o_per_ready = !fifo_full;
    assign o_dbg_state = state_q;

    assign o_wr_ram_op = wr_q.ram_op;
    assign o_wr_sfr_op = wr_q.sfr_op;
    assign o_wr_addr   = wr_q.addr;
    assign o_wr_data   = wr_q.data;
    assign o_wr_psw    = wr_q.psw;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IRQ_IDLE:   if (i_irq_push) state_d = IRQ_PUSH_L;
            IRQ_PUSH_L: state_d = IRQ_PUSH_H;
            IRQ_PUSH_H: state_d = IRQ_SP_UPD;
            IRQ_SP_UPD: state_d = IRQ_DONE;
            IRQ_DONE:   state_d = IRQ_IDLE;
            default:    state_d = IRQ_IDLE;
        endcase
    end

    always_comb begin
        wr_d.ram_op = OP_RAM_NOP;
        wr_d.sfr_op = OP_DEFAULT;
        wr_d.addr   = 8'h00;
        wr_d.data   = 8'h00;
        wr_d.psw    = 8'h00;
        if (state_q == IRQ_PUSH_L) begin
            wr_d.ram_op = OP_RAM_WR_BYTE;
            wr_d.addr   = sp_q + 8'd1;
            wr_d.data   = pc_q[7:0];
        end else if (state_q == IRQ_PUSH_H) begin
            wr_d.ram_op = OP_RAM_WR_BYTE;
            wr_d.addr   = sp_q + 8'd2;
            wr_d.data   = pc_q[15:8];
        end else if (state_q == IRQ_SP_UPD) begin
            wr_d.sfr_op = OP_SP_WR_BYTE;
            wr_d.addr   = SP_ADDR;
            wr_d.data   = sp_q + 8'd2;
        end else if (wb_grant) begin
            wr_d.ram_op = i_wb_ram_op;
            wr_d.sfr_op = i_wb_sfr_op;
            wr_d.addr   = i_wb_addr;
            wr_d.data   = i_wb_data;
            wr_d.psw    = i_wb_psw;
        end else if (per_grant) begin
            wr_d.sfr_op = fifo_rdata[FW-1:8];
            wr_d.data   = fifo_rdata[7:0];
        end
    end

    // Counts only cycles where a waiting peripheral entry lost to write-back.
    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || per_grant) begin
            starve_d = '0;
        end else if (wb_grant && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IRQ_IDLE;
            pc_q        <= 16'h0000;
            sp_q        <= 8'h00;
            starve_q    <= '0;
            wr_q.ram_op <= OP_RAM_NOP;
            wr_q.sfr_op <= OP_DEFAULT;
            wr_q.addr   <= 8'h00;
            wr_q.data   <= 8'h00;
            wr_q.psw    <= 8'h00;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            wr_q     <= wr_d;
            if ((state_q == IRQ_IDLE) && i_irq_push) begin
                pc_q <= i_irq_pc;
                sp_q <= i_sp;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected writes are queued as stimulus is
// driven and popped by a monitor whenever the write port shows a real operation.
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int RW = RAM_OP_LEN + SFR_OP_LEN + 24;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  wb_valid;
    logic [RAM_OP_LEN-1:0] wb_ram_op;
    logic [SFR_OP_LEN-1:0] wb_sfr_op;
    logic [7:0]            wb_addr, wb_data, wb_psw;
    logic                  wb_stall;
    logic                  irq_push;
    logic [15:0]           irq_pc;
    logic [7:0]            sp;
    logic                  irq_busy, irq_done;
    logic                  per_valid;
    logic [SFR_OP_LEN-1:0] per_sfr_op;
    logic [7:0]            per_data;
    logic                  per_ready;
    logic [RAM_OP_LEN-1:0] wr_ram_op;
    logic [SFR_OP_LEN-1:0] wr_sfr_op;
    logic [7:0]            wr_addr, wr_data, wr_psw;
    irq_state_e            dbg_state;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [RW-1:0] exp_q[$];

    wb_port_arbiter dut (
        .i_clk(clk), .i_rst(rst),
        .i_wb_valid(wb_valid), .i_wb_ram_op(wb_ram_op), .i_wb_sfr_op(wb_sfr_op),
        .i_wb_addr(wb_addr), .i_wb_data(wb_data), .i_wb_psw(wb_psw),
        .o_wb_stall(wb_stall),
        .i_irq_push(irq_push), .i_irq_pc(irq_pc), .i_sp(sp),
        .o_irq_busy(irq_busy), .o_irq_done(irq_done),
        .i_per_valid(per_valid), .i_per_sfr_op(per_sfr_op), .i_per_data(per_data),
        .o_per_ready(per_ready),
        .o_wr_ram_op(wr_ram_op), .o_wr_sfr_op(wr_sfr_op), .o_wr_addr(wr_addr),
        .o_wr_data(wr_data), .o_wr_psw(wr_psw),
        .o_dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] rec(input logic [RAM_OP_LEN-1:0] r, input logic [SFR_OP_LEN-1:0] s,
                                          input logic [7:0] a, input logic [7:0] d, input logic [7:0] p);
        return {r, s, a, d, p};
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_ram_op"}, 32'(wr_ram_op), 32'(OP_RAM_NOP));
        check({tag, "_sfr_op"}, 32'(wr_sfr_op), 32'(OP_DEFAULT));
        check({tag, "_addr"}, 32'(wr_addr), 32'h0);
        check({tag, "_data"}, 32'(wr_data), 32'h0);
        check({tag, "_psw"}, 32'(wr_psw), 32'h0);
        check({tag, "_busy"}, 32'(irq_busy), 32'h0);
        check({tag, "_done"}, 32'(irq_done), 32'h0);
    endtask

    // Scoreboard: every real write on the port must match the queue head in order.
    always @(negedge clk) begin
        if (!rst) begin
            if (irq_done === 1'b1) done_cnt++;
            if ((wr_ram_op !== OP_RAM_NOP) || (wr_sfr_op !== OP_DEFAULT)) begin
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", 32'({wr_ram_op, wr_sfr_op, wr_addr, wr_data, wr_psw}), 32'h0);
                end else begin
                    check("wr_port", 32'({wr_ram_op, wr_sfr_op, wr_addr, wr_data, wr_psw}),
                          32'(exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_wb(input logic v, input logic [7:0] a, input logic [7:0] d, input logic [7:0] p);
        wb_valid  = v;
        wb_ram_op = v ? OP_RAM_WR_BYTE : OP_RAM_NOP;
        wb_sfr_op = OP_DEFAULT;
        wb_addr   = a;
        wb_data   = d;
        wb_psw    = p;
    endtask

    // One cycle of write-back traffic with the stall the arbitration rules predict.
    task automatic wb_step(input logic v, input logic [7:0] a, input logic [7:0] d, input logic [7:0] p,
                           input logic exp_stall, input string tag);
        set_wb(v, a, d, p);
        #1;
        check({tag, "_stall"}, 32'(wb_stall), 32'(exp_stall));
        if (v && !exp_stall) exp_q.push_back(rec(OP_RAM_WR_BYTE, OP_DEFAULT, a, d, p));
        tick();
    endtask

    task automatic expect_push(input logic [7:0] s, input logic [15:0] pc);
        logic [7:0] a1, a2;
        a1 = s + 8'd1;
        a2 = s + 8'd2;
        exp_q.push_back(rec(OP_RAM_WR_BYTE, OP_DEFAULT, a1, pc[7:0], 8'h00));
        exp_q.push_back(rec(OP_RAM_WR_BYTE, OP_DEFAULT, a2, pc[15:8], 8'h00));
        exp_q.push_back(rec(OP_RAM_NOP, OP_SP_WR_BYTE, SP_ADDR, a2, 8'h00));
    endtask

    task automatic set_per(input logic v, input logic [SFR_OP_LEN-1:0] op, input logic [7:0] d);
        per_valid  = v;
        per_sfr_op = op;
        per_data   = d;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        set_wb(1'b0, 8'h00, 8'h00, 8'h00);
        irq_push = 1'b0; irq_pc = 16'h0000; sp = 8'h00;
        set_per(1'b0, OP_DEFAULT, 8'h00);
        tick(); tick();
        check_quiet("rst");
        check("rst_state", 32'(dbg_state), 32'(IRQ_IDLE));
        rst = 1'b0;

        // 1: idle after reset
        repeat (5) tick();
        check_quiet("idle");
        check("idle_stall", 32'(wb_stall), 32'h0);
        check("idle_ready", 32'(per_ready), 32'h1);

        // 2: push sp=0x07 pc=0x1234, WB competing throughout
        irq_push = 1'b1; irq_pc = 16'h1234; sp = 8'h07;
        wb_step(1'b1, 8'h30, 8'hA5, 8'h11, 1'b0, "p2_c0");
        expect_push(8'h07, 16'h1234);
        irq_push = 1'b0; irq_pc = 16'hFFFF; sp = 8'hEE;
        check("p2_busy_l", 32'(irq_busy), 32'h1);
        wb_step(1'b1, 8'h31, 8'hB6, 8'h22, 1'b1, "p2_l");
        check("p2_busy_h", 32'(irq_busy), 32'h1);
        wb_step(1'b1, 8'h31, 8'hB6, 8'h22, 1'b1, "p2_h");
        check("p2_busy_sp", 32'(irq_busy), 32'h1);
        wb_step(1'b1, 8'h31, 8'hB6, 8'h22, 1'b1, "p2_sp");
        check("p2_done", 32'(irq_done), 32'h1);
        check("p2_busy_done", 32'(irq_busy), 32'h0);
        wb_step(1'b1, 8'h31, 8'hB6, 8'h22, 1'b0, "p2_dn");
        check("p2_done_off", 32'(irq_done), 32'h0);
        set_wb(1'b0, 8'h00, 8'h00, 8'h00);
        tick(); tick();
        check("p2_done_cnt", 32'(done_cnt), 32'd1);

        // 3: wrap-around push sp=0xFE
        irq_push = 1'b1; irq_pc = 16'hABCD; sp = 8'hFE;
        expect_push(8'hFE, 16'hABCD);
        tick();
        irq_push = 1'b0;
        repeat (6) tick();
        check("p3_done_cnt", 32'(done_cnt), 32'd2);
        check("p3_q_empty", 32'(exp_q.size()), 32'd0);

        // 4: one FIFO entry starved by continuous WB, then forced
        set_per(1'b1, 3'd5, 8'h5A);
        #1;
        check("p4_ready", 32'(per_ready), 32'h1);
        tick();
        set_per(1'b0, OP_DEFAULT, 8'h00);
        wb_step(1'b1, 8'h40, 8'h01, 8'h71, 1'b0, "p4_w1");
        wb_step(1'b1, 8'h41, 8'h02, 8'h72, 1'b0, "p4_w2");
        wb_step(1'b1, 8'h42, 8'h03, 8'h73, 1'b0, "p4_w3");
        exp_q.push_back(rec(OP_RAM_NOP, 3'd5, 8'h00, 8'h5A, 8'h00));
        wb_step(1'b1, 8'h43, 8'h04, 8'h74, 1'b1, "p4_force");
        wb_step(1'b1, 8'h43, 8'h04, 8'h74, 1'b0, "p4_w4");
        set_wb(1'b0, 8'h00, 8'h00, 8'h00);
        tick(); tick();
        check("p4_q_empty", 32'(exp_q.size()), 32'd0);

        // 5: fill the FIFO behind busy WB, 5th request waits for space
        for (int k = 0; k < 4; k++) begin
            set_per(1'b1, 3'(k + 2), 8'(8'h90 + k));
            wb_step(1'b1, 8'(8'h50 + k), 8'(8'h60 + k), 8'h33, 1'b0, "p5_fill");
        end
        set_per(1'b1, 3'd7, 8'h9F);
        #1;
        check("p5_full_ready", 32'(per_ready), 32'h0);
        exp_q.push_back(rec(OP_RAM_NOP, 3'd2, 8'h00, 8'h90, 8'h00));
        wb_step(1'b1, 8'h54, 8'h64, 8'h33, 1'b1, "p5_force");
        check("p5_ready_again", 32'(per_ready), 32'h1);
        wb_step(1'b1, 8'h54, 8'h64, 8'h33, 1'b0, "p5_w4");
        set_per(1'b0, OP_DEFAULT, 8'h00);
        set_wb(1'b0, 8'h00, 8'h00, 8'h00);
        for (int k = 1; k < 4; k++)
            exp_q.push_back(rec(OP_RAM_NOP, 3'(k + 2), 8'h00, 8'(8'h90 + k), 8'h00));
        exp_q.push_back(rec(OP_RAM_NOP, 3'd7, 8'h00, 8'h9F, 8'h00));
        repeat (7) tick();
        check("p5_q_empty", 32'(exp_q.size()), 32'd0);
        check("p5_ready_idle", 32'(per_ready), 32'h1);

        // 6: reset during PUSH_H abandons the push
        irq_push = 1'b1; irq_pc = 16'h5678; sp = 8'h20;
        exp_q.push_back(rec(OP_RAM_WR_BYTE, OP_DEFAULT, 8'h21, 8'h78, 8'h00));
        tick();
        irq_push = 1'b0;
        check("p6_state_l", 32'(dbg_state), 32'(IRQ_PUSH_L));
        tick();
        check("p6_state_h", 32'(dbg_state), 32'(IRQ_PUSH_H));
        @(negedge clk);
        #1;
        rst = 1'b1;
        tick();
        check_quiet("p6_rst");
        check("p6_state_rst", 32'(dbg_state), 32'(IRQ_IDLE));
        rst = 1'b0;
        repeat (4) tick();
        check("p6_no_done", 32'(done_cnt), 32'd2);
        check("p6_q_empty", 32'(exp_q.size()), 32'd0);
        irq_push = 1'b1; irq_pc = 16'h9ABC; sp = 8'h30;
        expect_push(8'h30, 16'h9ABC);
        tick();
        irq_push = 1'b0;
        repeat (6) tick();
        check("p6_done_cnt", 32'(done_cnt), 32'd3);
        check("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
